nibble_cmp_seq: RTL

Sequential magnitude-compare controller. It compares two WIDTH-bit unsigned operands by stepping a single 4-bit magnitude-compare slice across the nibbles, most significant nibble first. The slice is the same gt/eq/lt structure the team uses for 4-bit compares. The block gives wide compares a start/busy/done handshake so the wide datapath never needs a full parallel comparator tree.

---
 rtl/nibble_cmp_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/nibble_cmp_seq.sv
// nibble_cmp_seq: sequential WIDTH-bit unsigned magnitude compare using one 4-bit slice, MSB nibble first
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   compare request, accepted only in IDLE
//   A, B    in   WIDTH-bit operands, latched on an accepted start
//   busy    out  high in every compare (CMP) cycle
//   done    out  one-cycle pulse in the FIN cycle; flags are valid from this cycle
//   A_gt_B  out  result A > B, held until the next accepted start
//   A_eq_B  out  result A == B, held until the next accepted start
//   A_lt_B  out  result A < B, held until the next accepted start
//
// Build option NIBBLE_CMP_EARLY_EXIT_EN: when defined, the compare finishes on the
// first differing nibble; when undefined, the first difference is kept sticky
// and all NIB nibbles are always scanned (fixed latency). Flags are identical.
module nibble_cmp_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             A_gt_B,
    output logic             A_eq_B,
    output logic             A_lt_B
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, CMP, FIN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
`ifndef NIBBLE_CMP_EARLY_EXIT_EN
    // First-difference result, frozen once a nibble differs so lower nibbles cannot override it
    logic             sgt_q, sgt_d;
    logic             slt_q, slt_d;
    logic             sgt_n, slt_n;
`endif

    logic [3:0] a_nib, b_nib;
    logic       nib_gt, nib_lt;

    // Nibble mux driven by the scan index
    always_comb begin
        a_nib = 4'h0;
        b_nib = 4'h0;
        for (int i = 0; i < NIB; i++) begin
            if (idx_q == IW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
    end

    // 4-bit magnitude-compare slice; eq is implied by neither gt nor lt
    assign nib_gt = a_nib > b_nib;
    assign nib_lt = a_nib < b_nib;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
`ifndef NIBBLE_CMP_EARLY_EXIT_EN
        sgt_d   = sgt_q;
        slt_d   = slt_q;
        sgt_n   = (sgt_q | slt_q) ? sgt_q : nib_gt;
        slt_n   = (sgt_q | slt_q) ? slt_q : nib_lt;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    idx_d   = IW'(NIB - 1);
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
`ifndef NIBBLE_CMP_EARLY_EXIT_EN
                    sgt_d   = 1'b0;
                    slt_d   = 1'b0;
`endif
                    state_d = CMP;
                end
            end
            CMP: begin
`ifdef NIBBLE_CMP_EARLY_EXIT_EN
                if (nib_gt | nib_lt) begin
                    gt_d    = nib_gt;
                    lt_d    = nib_lt;
                    state_d = FIN;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q - 1'b1;
                end
`else
                sgt_d = sgt_n;
                slt_d = slt_n;
                if (idx_q == '0) begin
                    gt_d    = sgt_n;
                    lt_d    = slt_n;
                    eq_d    = ~(sgt_n | slt_n);
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q - 1'b1;
                end
`endif
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
`ifndef NIBBLE_CMP_EARLY_EXIT_EN
            sgt_q   <= 1'b0;
            slt_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
`ifndef NIBBLE_CMP_EARLY_EXIT_EN
            sgt_q   <= sgt_d;
            slt_q   <= slt_d;
`endif
        end
    end

    assign busy   = state_q == CMP;
    assign done   = state_q == FIN;
    assign A_gt_B = gt_q;
    assign A_eq_B = eq_q;
    assign A_lt_B = lt_q;
endmodule
